// File: rtl/jc_phase_decoder_if.sv
// jc_phase_decoder_if: bundle between a 3-bit-style Johnson counter consumer and the
// phase decoder. The master modport belongs to whoever feeds the code and clears the
// sticky error; the slave modport is the decoder itself.
interface jc_phase_decoder_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned REV_W = 8
);
  localparam int unsigned PW = $clog2(2 * N);

  logic [N-1:0]     i_Q;
  logic             i_err_clr;
  logic [PW-1:0]    o_phase;
  logic [2*N-1:0]   o_onehot;
  logic             o_valid;
  logic             o_step;
  logic             o_wrap;
  logic             o_dir;
  logic [REV_W-1:0] o_rev_cnt;
  logic             o_err;
  logic             o_err_sticky;

  modport master (
    output i_Q,
    output i_err_clr,
    input  o_phase,
    input  o_onehot,
    input  o_valid,
    input  o_step,
    input  o_wrap,
    input  o_dir,
    input  o_rev_cnt,
    input  o_err,
    input  o_err_sticky
  );

  modport slave (
    input  i_Q,
    input  i_err_clr,
    output o_phase,
    output o_onehot,
    output o_valid,
    output o_step,
    output o_wrap,
    output o_dir,
    output o_rev_cnt,
    output o_err,
    output o_err_sticky
  );
endinterface

// File: rtl/jc_phase_decoder.sv
// jc_phase_decoder: validates an N-bit Johnson code against the legal 2N-state ring,
// decodes it to a phase index / one-hot vector, emits step and wrap pulses, counts
// revolutions and flags illegal codes or skipped states.
// Optional feature: define JC_DEC_REVERSE_EN to accept reverse stepping (o_dir, reverse
// wrap decrements o_rev_cnt). Without it a reverse step is treated as a skip.
module jc_phase_decoder #(
  parameter int unsigned N     = 3,
  parameter int unsigned REV_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  jc_phase_decoder_if.slave io_bus
);
  localparam int unsigned   NumPh  = 2 * N;
  localparam int unsigned   PW     = $clog2(NumPh);
  localparam logic [PW-1:0] LastPh = PW'(NumPh - 1);
  localparam logic [N-1:0]  Ones   = '1;

  typedef enum logic [1:0] {StIdle, StAcq, StLock} state_e;

  // Legal code for phase k, MSB first: k<=N fills ones from the top, k>N drains them.
  function automatic logic [N-1:0] code_of(input int unsigned k);
    return (k <= N) ? ~(Ones >> k) : (Ones >> (k - N));
  endfunction

  // Registered state and outputs
  logic [N-1:0]     r_q;
  logic [N-1:0]     r_qp;
  state_e           r_state;
  logic [PW-1:0]    r_phase;
  logic [NumPh-1:0] r_onehot;
  logic             r_valid;
  logic             r_step;
  logic             r_wrap;
  logic             r_err;
  logic             r_err_sticky;
  logic [REV_W-1:0] r_rev_cnt;
`ifdef JC_DEC_REVERSE_EN
  logic             r_dir;
`endif

  // Decode / classification wires
  logic             w_q_legal;
  logic             w_p_legal;
  logic [PW-1:0]    w_q_phase;
  logic [PW-1:0]    w_p_phase;
  logic [PW-1:0]    w_next_ph;
  logic             w_hold;
  logic             w_fwd;
  logic             w_fwd_wrap;
  logic             w_adv;
  logic             w_wrap;
`ifdef JC_DEC_REVERSE_EN
  logic [PW-1:0]    w_prev_ph;
  logic             w_rev;
  logic             w_rev_wrap;
`endif

  // Look up the current and previous sampled codes in the legal ring
  always_comb begin
    w_q_legal = 1'b0;
    w_p_legal = 1'b0;
    w_q_phase = '0;
    w_p_phase = '0;
    for (int unsigned k = 0; k < NumPh; k++) begin
      if (r_q == code_of(k)) begin
        w_q_legal = 1'b1;
        w_q_phase = PW'(k);
      end
      if (r_qp == code_of(k)) begin
        w_p_legal = 1'b1;
        w_p_phase = PW'(k);
      end
    end
  end

  // Classify the q_p -> q_r transition as hold / forward / (reverse) / error
  always_comb begin
    w_next_ph  = (w_p_phase == LastPh) ? '0 : w_p_phase + PW'(1);
    w_hold     = w_q_legal && (r_q == r_qp);
    w_fwd      = w_q_legal && w_p_legal && !w_hold && (w_q_phase == w_next_ph);
    w_fwd_wrap = w_fwd && (w_p_phase == LastPh);
`ifdef JC_DEC_REVERSE_EN
    w_prev_ph  = (w_p_phase == '0) ? LastPh : w_p_phase - PW'(1);
    w_rev      = w_q_legal && w_p_legal && !w_hold && (w_q_phase == w_prev_ph);
    w_rev_wrap = w_rev && (w_p_phase == '0);
    w_adv      = w_fwd || w_rev;
    w_wrap     = w_fwd_wrap || w_rev_wrap;
`else
    w_adv      = w_fwd;
    w_wrap     = w_fwd_wrap;
`endif
  end

  // Input pipeline, lock FSM and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q          <= '0;
      r_qp         <= '0;
      r_state      <= StIdle;
      r_phase      <= '0;
      r_onehot     <= '0;
      r_valid      <= 1'b0;
      r_step       <= 1'b0;
      r_wrap       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_rev_cnt    <= '0;
`ifdef JC_DEC_REVERSE_EN
      r_dir        <= 1'b0;
`endif
    end else begin
      r_q    <= io_bus.i_Q;
      r_qp   <= r_q;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (w_q_legal) begin
        r_phase <= w_q_phase;
      end
      // A new error later in this block overrides the clear
      if (io_bus.i_err_clr) begin
        r_err_sticky <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          r_valid  <= 1'b0;
          r_onehot <= '0;
          if (w_q_legal) begin
            r_state <= StAcq;
          end
        end
        StAcq, StLock: begin
          if (w_hold) begin
            // Nothing moves; o_valid / o_onehot keep their values
          end else if (w_adv) begin
            r_state  <= StLock;
            r_valid  <= 1'b1;
            r_onehot <= NumPh'(1) << w_q_phase;
            // The locking step itself is not reported as a step, but a wrap still counts
            r_step   <= (r_state == StLock);
            r_wrap   <= w_wrap;
`ifdef JC_DEC_REVERSE_EN
            r_dir    <= w_rev;
            if (w_fwd_wrap) begin
              r_rev_cnt <= r_rev_cnt + REV_W'(1);
            end else if (w_rev_wrap) begin
              r_rev_cnt <= r_rev_cnt - REV_W'(1);
            end
`else
            if (w_fwd_wrap) begin
              r_rev_cnt <= r_rev_cnt + REV_W'(1);
            end
`endif
          end else begin
            r_state      <= StIdle;
            r_valid      <= 1'b0;
            r_onehot     <= '0;
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_valid  <= 1'b0;
          r_onehot <= '0;
        end
      endcase
    end
  end

  assign io_bus.o_phase      = r_phase;
  assign io_bus.o_onehot     = r_onehot;
  assign io_bus.o_valid      = r_valid;
  assign io_bus.o_step       = r_step;
  assign io_bus.o_wrap       = r_wrap;
  assign io_bus.o_rev_cnt    = r_rev_cnt;
  assign io_bus.o_err        = r_err;
  assign io_bus.o_err_sticky = r_err_sticky;
`ifdef JC_DEC_REVERSE_EN
  assign io_bus.o_dir        = r_dir;
`else
  assign io_bus.o_dir        = 1'b0;
`endif

endmodule
